// File: rtl/digit_scan_mux.sv
// Four-digit time-multiplexed display scanner. It holds a 16-bit shadow value and
// steps one active-low digit enable every DIV clocks, with optional leading-zero blanking.
module digit_scan_mux #(
  parameter int unsigned DIV = 50000
) (
  input  logic        JM1222HM_clk,
  input  logic        JM1222HM_rst,
  input  logic [15:0] JM1222HM_value,
  input  logic        JM1222HM_load,
  input  logic        JM1222HM_lzb_en,
  output logic [3:0]  JM1222HM_digit,
  output logic [3:0]  JM1222HM_an,
  output logic        JM1222HM_load_ack,
  output logic        JM1222HM_frame
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic [15:0]   shadow;
  logic          first_tick;
  logic          tick;
  logic          upper_zero;
  logic          blank;
  logic [3:0]    sel_nibble;
  logic [3:0]    next_an;
  logic [3:0]    next_digit;

  assign tick     = (presc == TERM);
  assign next_idx = idx + 2'd1;

  always_ff @(posedge JM1222HM_clk or posedge JM1222HM_rst) begin
    if (JM1222HM_rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // load is a one-way strobe with no back-pressure: every cycle with load=1 captures
  // value at that edge, and load_ack repeats the strobe exactly one cycle later.
  always_ff @(posedge JM1222HM_clk or posedge JM1222HM_rst) begin
    if (JM1222HM_rst) begin
      shadow            <= '0;
      JM1222HM_load_ack <= 1'b0;
    end else begin
      JM1222HM_load_ack <= JM1222HM_load;
      if (JM1222HM_load) begin
        shadow <= JM1222HM_value;
      end
    end
  end

  // Nibble and blanking decision for the slot being entered; shadow here is the
  // pre-load value when a load lands on a tick edge.
  always_comb begin
    sel_nibble = 4'h0;
    upper_zero = 1'b0;
    case (next_idx)
      2'd0: begin
        sel_nibble = shadow[3:0];
        upper_zero = 1'b0;
      end
      2'd1: begin
        sel_nibble = shadow[7:4];
        upper_zero = (shadow[15:4] == 12'h000);
      end
      2'd2: begin
        sel_nibble = shadow[11:8];
        upper_zero = (shadow[15:8] == 8'h00);
      end
      default: begin
        sel_nibble = shadow[15:12];
        upper_zero = (shadow[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    blank      = JM1222HM_lzb_en & upper_zero;
    next_an    = 4'b1111;
    next_digit = 4'h0;
    if (!blank) begin
      next_an    = ~(4'b0001 << next_idx);
      next_digit = sel_nibble;
    end
  end

  // Digit and enables only move on tick edges, so the display holds steady mid-slot.
  always_ff @(posedge JM1222HM_clk or posedge JM1222HM_rst) begin
    if (JM1222HM_rst) begin
      idx            <= 2'd3;
      first_tick     <= 1'b1;
      JM1222HM_digit <= 4'h0;
      JM1222HM_an    <= 4'b1111;
      JM1222HM_frame <= 1'b0;
    end else begin
      JM1222HM_frame <= tick & (idx == 2'd3) & ~first_tick;
      if (tick) begin
        idx            <= next_idx;
        first_tick     <= 1'b0;
        JM1222HM_digit <= next_digit;
        JM1222HM_an    <= next_an;
      end
    end
  end

endmodule
